// File: rtl/risc8_mem_arbiter.sv
// Single-port RAM arbiter for the risc8 core: fetch, data and stack requesters share one port.
// Fixed priority with a fetch anti-starvation override, a one-grant data lock, and tagged read return.
module risc8_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starved
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  // Winner encoding doubles as the read-return tag (NONE also marks writes).
  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_F    = 2'b01,
    SRC_D    = 2'b10,
    SRC_S    = 2'b11
  } src_e;

  src_e          win;
  logic          force_f;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  src_e          tag_d;
  src_e          tag_q [READ_LAT];
  src_e          tag_out;

  always_comb begin
    win     = SRC_NONE;
    force_f = 1'b0;
    if (rst) begin
      win = SRC_NONE;
    end else if (lock_q && d_req) begin
      win = SRC_D;
    end else if ((cnt_q == CNT_MAX) && f_req) begin
      win     = SRC_F;
      force_f = 1'b1;
    end else if (d_req) begin
      win = SRC_D;
    end else if (s_req) begin
      win = SRC_S;
    end else if (f_req) begin
      win = SRC_F;
    end
  end

  assign f_gnt   = (win == SRC_F);
  assign d_gnt   = (win == SRC_D);
  assign s_gnt   = (win == SRC_S);
  assign mem_en  = f_gnt | d_gnt | s_gnt;
  assign starved = force_f;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = f_addr;
    mem_wdata = d_wdata;
    case (win)
      SRC_D: begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      SRC_S: begin
        mem_we    = s_we;
        mem_addr  = s_addr;
        mem_wdata = s_wdata;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = f_addr;
        mem_wdata = d_wdata;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!f_req || f_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign lock_d = d_gnt & d_lock & ~d_we;
  assign tag_d  = (mem_en && !mem_we) ? win : SRC_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) begin
        tag_q[i] <= SRC_NONE;
      end
    end else begin
      cnt_q    <= cnt_d;
      lock_q   <= lock_d;
      tag_q[0] <= tag_d;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Tags leaving the pipe line up with mem_rdata; reset masks them so in-flight reads vanish.
  assign tag_out  = tag_q[READ_LAT-1];
  assign f_rvalid = ~rst & (tag_out == SRC_F);
  assign d_rvalid = ~rst & (tag_out == SRC_D);
  assign s_rvalid = ~rst & (tag_out == SRC_S);

endmodule

// File: tb/tb_risc8_mem_arbiter.sv
// Directed bench for risc8_mem_arbiter: one instance at READ_LAT=1 and one at READ_LAT=2, shared inputs.
module tb_risc8_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_we, d_lock, s_req, s_we;
  logic [15:0] f_addr, d_addr, s_addr;
  logic [7:0]  d_wdata, s_wdata, mem_rdata;

  logic        f_gnt, f_rv1, d_gnt, d_rv1, s_gnt, s_rv1;
  logic        mem_en, mem_we, starved;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  logic        f_gnt2, f_rv2, d_gnt2, d_rv2, s_gnt2, s_rv2;
  logic        mem_en2, mem_we2, starved2;
  logic [15:0] mem_addr2;
  logic [7:0]  mem_wdata2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  risc8_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_LAT(1), .STARVE_MAX(3)) u1 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rv1),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rv1),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rv1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starved(starved)
  );

  risc8_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_LAT(2), .STARVE_MAX(3)) u2 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt2), .f_rvalid(f_rv2),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rv2),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt2), .s_rvalid(s_rv2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata), .starved(starved2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant vector {f,d,s} for both instances must agree with the expectation.
  task automatic chk_gnt(input string tag, input logic [2:0] exp);
    chk({tag, "_gnt1"}, {29'd0, f_gnt, d_gnt, s_gnt}, {29'd0, exp});
    chk({tag, "_gnt2"}, {29'd0, f_gnt2, d_gnt2, s_gnt2}, {29'd0, exp});
  endtask

  task automatic chk_rv1(input string tag, input logic [2:0] exp);
    chk({tag, "_rv1"}, {29'd0, f_rv1, d_rv1, s_rv1}, {29'd0, exp});
  endtask

  task automatic chk_rv2(input string tag, input logic [2:0] exp);
    chk({tag, "_rv2"}, {29'd0, f_rv2, d_rv2, s_rv2}, {29'd0, exp});
  endtask

  initial begin
    logic [2:0] exp_g;
    logic       prev_f, prev_d;

    rst = 1'b1;
    f_req = 0; d_req = 0; d_we = 0; d_lock = 0; s_req = 0; s_we = 0;
    f_addr = '0; d_addr = '0; s_addr = '0; d_wdata = '0; s_wdata = '0;
    mem_rdata = 8'h00;

    // C0: reset with every request high
    @(negedge clk);
    f_req = 1; d_req = 1; s_req = 1;
    #1;
    chk_gnt("rst", 3'b000);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_starved", {31'd0, starved}, 32'd0);
    chk_rv1("rst", 3'b000);
    chk_rv2("rst", 3'b000);

    // C1: single fetch
    @(negedge clk);
    rst = 0; d_req = 0; s_req = 0; f_req = 1; f_addr = 16'h0010; mem_rdata = 8'h3C;
    #1;
    chk_gnt("fetch", 3'b100);
    chk("fetch_mem_en", {31'd0, mem_en}, 32'd1);
    chk("fetch_mem_addr", {16'd0, mem_addr}, 32'h0010);
    chk("fetch_mem_we", {31'd0, mem_we}, 32'd0);

    // C2: fetch data returns after one cycle on u1 only
    @(negedge clk);
    f_req = 0;
    #1;
    chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
    chk_rv1("fetch_lat1", 3'b100);
    chk_rv2("fetch_lat1", 3'b000);

    // C3: all three request; data write wins
    @(negedge clk);
    f_req = 1; f_addr = 16'h0010;
    d_req = 1; d_we = 1; d_addr = 16'h8000; d_wdata = 8'hA5;
    s_req = 1; s_we = 0; s_addr = 16'h0200;
    #1;
    chk_gnt("all3", 3'b010);
    chk("all3_mem_we", {31'd0, mem_we}, 32'd1);
    chk("all3_mem_wdata", {24'd0, mem_wdata}, 32'h00A5);
    chk("all3_mem_addr", {16'd0, mem_addr}, 32'h8000);
    chk_rv1("all3", 3'b000);
    chk_rv2("fetch_lat2", 3'b100);

    // C4: data dropped, stack read wins over fetch
    @(negedge clk);
    d_req = 0; d_we = 0;
    #1;
    chk_gnt("stack", 3'b001);
    chk("stack_mem_addr", {16'd0, mem_addr}, 32'h0200);
    chk("stack_mem_we", {31'd0, mem_we}, 32'd0);
    chk_rv1("wr_no_rv", 3'b000);

    // C5: fetch denied twice only, so no override yet
    @(negedge clk);
    s_req = 0;
    #1;
    chk_gnt("fetch2", 3'b100);
    chk("fetch2_starved", {31'd0, starved}, 32'd0);
    chk_rv1("stack_lat1", 3'b001);

    // C6..C13: data held with fetch pending; fetch forced every 4th cycle
    f_addr = 16'h0050;
    prev_f = 1'b1; prev_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      f_req = 1; d_req = 1; d_we = 0; d_addr = 16'h0300;
      #1;
      exp_g = (i == 3 || i == 7) ? 3'b100 : 3'b010;
      chk_gnt($sformatf("starve%0d", i), exp_g);
      chk($sformatf("starve%0d_flag", i), {31'd0, starved}, {31'd0, exp_g[2]});
      chk($sformatf("starve%0d_addr", i), {16'd0, mem_addr},
          exp_g[2] ? 32'h0050 : 32'h0300);
      chk_rv1($sformatf("starve%0d", i), {prev_f, prev_d, 1'b0});
      if (i == 0) chk_rv2("stack_lat2", 3'b001);
      prev_f = exp_g[2]; prev_d = exp_g[1];
    end

    // C14..C18: lock taken on the read that saturates the counter
    f_addr = 16'h0040;
    @(negedge clk);
    d_addr = 16'h00FE;
    #1;
    chk_gnt("lk_a", 3'b010);
    @(negedge clk);
    d_addr = 16'h00FF;
    #1;
    chk_gnt("lk_b", 3'b010);
    @(negedge clk);
    d_addr = 16'h0100; d_lock = 1;
    #1;
    chk_gnt("lk_c", 3'b010);
    chk("lk_c_addr", {16'd0, mem_addr}, 32'h0100);
    @(negedge clk);
    d_addr = 16'h0101; d_lock = 0;
    #1;
    chk_gnt("lk_hold", 3'b010);
    chk("lk_hold_starved", {31'd0, starved}, 32'd0);
    chk("lk_hold_addr", {16'd0, mem_addr}, 32'h0101);
    @(negedge clk);
    #1;
    chk_gnt("lk_rel", 3'b100);
    chk("lk_rel_starved", {31'd0, starved}, 32'd1);
    chk("lk_rel_addr", {16'd0, mem_addr}, 32'h0040);

    // C19..C24: back-to-back F, D, S reads; u2 returns them two cycles later
    @(negedge clk);
    f_req = 1; d_req = 0; s_req = 0;
    #1;
    chk_gnt("b2b_f", 3'b100);
    @(negedge clk);
    f_req = 0; d_req = 1; d_we = 0; d_addr = 16'h0400;
    #1;
    chk_gnt("b2b_d", 3'b010);
    @(negedge clk);
    d_req = 0; s_req = 1; s_we = 0; s_addr = 16'h0500;
    #1;
    chk_gnt("b2b_s", 3'b001);
    chk_rv2("b2b_c3", 3'b100);
    @(negedge clk);
    s_req = 0;
    #1;
    chk_rv2("b2b_c4", 3'b010);
    @(negedge clk);
    #1;
    chk_rv2("b2b_c5", 3'b001);
    @(negedge clk);
    #1;
    chk_rv2("b2b_c6", 3'b000);

    // C25..C27: reset right after a data read drops its return
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 16'h0600;
    #1;
    chk_gnt("prerst_d", 3'b010);
    @(negedge clk);
    rst = 1; d_req = 0; f_req = 1;
    #1;
    chk_gnt("inrst", 3'b000);
    chk("inrst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("inrst_starved", {31'd0, starved}, 32'd0);
    chk_rv1("inrst", 3'b000);
    chk_rv2("inrst", 3'b000);
    @(negedge clk);
    rst = 0; f_req = 0;
    #1;
    chk_rv1("postrst", 3'b000);
    chk_rv2("postrst", 3'b000);
    chk("postrst_mem_en", {31'd0, mem_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc8_mem_arbiter.md
Name: risc8_mem_arbiter

Overview:
Single-port memory arbiter for the risc8 core. It shares one synchronous RAM port between three requesters: instruction fetch, data access (LWHI/LWLO/SWHI/SWLO) and stack access (PUSH/POP/CALL/RET). It issues at most one memory access per cycle, using fixed priority with a fetch anti-starvation override and an optional data lock for back-to-back hi/lo pairs. Read data returns after a fixed latency, tagged to the requester that issued the read.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, word width (matches risc8 word)
READ_LAT, 1, memory read latency in cycles (1..3)
STARVE_MAX, 3, consecutive denied fetch cycles before fetch is forced to win

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
f_req  in  1  fetch request (read only)
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch granted this cycle
f_rvalid  out  1  fetch read data valid on mem_rdata
d_req  in  1  data request
d_we  in  1  data write enable
d_lock  in  1  keep grant on data for the next cycle
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write value
d_gnt  out  1  data granted
d_rvalid  out  1  data read valid
s_req  in  1  stack request
s_we  in  1  stack write (push)
s_addr  in  ADDR_W  stack address
s_wdata  in  DATA_W  stack write value
s_gnt  out  1  stack granted
s_rvalid  out  1  stack read valid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data (shared with requesters)
starved  out  1  forced-fetch override active this cycle

Behaviour:
- Clock is clk. Reset is rst: one clock, reset synchronous and active-high.
- Reset: every gnt, rvalid, mem_en, mem_we and starved output is 0. The starve counter, lock flag and read-tag pipeline are cleared. Reads in flight at reset are dropped, with no rvalid afterwards.
- Handshake: a requester holds req, addr, we and wdata stable until its gnt is seen. Each gnt is a combinational function of registered state and the current reqs. The gnt cycle is the memory access cycle. A write completes in its gnt cycle. A requester may keep req high after gnt to issue a new access the next cycle.
- At most one gnt per cycle. mem_en = OR of the gnts. mem_* are muxed from the winner; mem_we = winner's we (0 for fetch). When there is no winner, mem_en=0, mem_we=0 and addr/wdata are don't-care.
- Priority, first match wins:
  1. Lock held (lock_q=1) and d_req=1 -> data.
  2. starve_cnt==STARVE_MAX and f_req=1 -> fetch; starved=1.
  3. d_req -> data.
  4. s_req -> stack.
  5. f_req -> fetch.
- Lock:
  - lock_q <= d_gnt & d_lock & ~d_we.
  - A lock held with d_req=0 is released and normal priority applies that cycle.
  - A lock lasts one extra grant per assertion; it is chained by holding d_lock.
  - The lock beats the starvation override. The counter saturates at STARVE_MAX while the lock holds.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Cleared when f_gnt=1 or f_req=0.
  - Otherwise it increments and saturates at STARVE_MAX.
- Read return: on a read gnt, a 2-bit tag (F/D/S) enters a READ_LAT-deep shift register. When the tag exits, exactly one matching rvalid pulses for one cycle, aligned with mem_rdata. Writes push an empty tag. Reads are pipelined; a new read is issued every cycle with no bubbles.
- Simultaneous gnt and rvalid to the same or different requesters is legal.

Test Plan:
- After rst, with f_req=1 and f_addr=0x0010 -> f_gnt=1 in the same cycle, mem_en=1, mem_addr=0x0010, mem_we=0; f_rvalid=1 exactly READ_LAT(1) cycles later with mem_rdata.
- f_req, d_req(we=1, addr=0x8000, wdata=0xA5) and s_req all high in one cycle -> d_gnt only, with mem_we=1 and mem_wdata=0xA5. The next cycle with d_req dropped -> s_gnt.
- d_req held high continuously with f_req=1, STARVE_MAX=3 -> d_gnt for 3 cycles, then f_gnt with starved=1 on cycle 4, then d_gnt again; the pattern repeats.
- d_lock=1 on a read gnt to 0x0100, with f starved (cnt=3) -> next cycle d_gnt (0x0101) wins over forced fetch. The cycle after that (lock released) -> f_gnt with starved=1.
- Back-to-back reads F, D, S in 3 cycles with READ_LAT=2 -> rvalid f, d, s pulse on cycles 3, 4, 5, one each.
- rst asserted for one cycle the clock after a d read gnt -> no d_rvalid follows; all outputs 0 during rst.
